// File: rtl/me_operand_fifo_pkg.sv
// Shared constants and width helpers for the modular-exponentiation operand FIFO.
package me_operand_fifo_pkg;

  localparam int M_SIZE        = 3072;
  localparam int URAM_ADDR     = 12;
  localparam int ME_FIFO_DEPTH = 4;
  localparam int ME_FIFO_AFULL = 3;

  // Encodes which of push/pop were accepted at the current edge.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Pointers carry one extra wrap bit above the address.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/me_operand_fifo_if.sv
// Producer/consumer bus of the operand FIFO; master drives strobes, slave is the FIFO.
interface me_operand_fifo_if
  import me_operand_fifo_pkg::*;
#(
  parameter int WIDTH = M_SIZE,
  parameter int CNT_W = cnt_w(ME_FIFO_DEPTH)
);

  logic             flush;
  logic             write_fifo;
  logic [WIDTH-1:0] data_fifo;
  logic             wfull;
  logic             walmost_full;
  logic             rd_fifo;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             udf;

  modport master (
    output flush, write_fifo, data_fifo, rd_fifo,
    input  wfull, walmost_full, rdata, rvalid, rempty, count, ovf, udf
  );

  modport slave (
    input  flush, write_fifo, data_fifo, rd_fifo,
    output wfull, walmost_full, rdata, rvalid, rempty, count, ovf, udf
  );

endinterface

// File: rtl/me_operand_fifo_mem.sv
// DEPTH x WIDTH operand storage: one synchronous write port, one asynchronous read port.
module me_fifo_mem #(
  parameter int WIDTH  = 3072,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  // Operand storage is intentionally not reset; pointers define validity.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/me_operand_fifo.sv
// Operand FIFO between URAM read stage and Montgomery multiplier.
// Define ME_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module me_operand_fifo
  import me_operand_fifo_pkg::*;
#(
  parameter int WIDTH     = M_SIZE,
  parameter int DEPTH     = ME_FIFO_DEPTH,
  parameter int AFULL_LVL = ME_FIFO_AFULL
) (
  input  logic             clk,
  input  logic             rst_n,
  me_operand_fifo_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full, r_empty, r_afull;
  logic             r_ovf, r_udf;

  logic             w_push_req, w_pop_req;
  logic             w_push, w_pop;
  fifo_op_e         w_op;
  logic [PTR_W-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_full_nxt, w_empty_nxt, w_afull_nxt;
  logic [WIDTH-1:0] w_mem_rdata;

  // Flush swallows same-cycle strobes so they neither move state nor raise flags.
  assign w_push_req = bus.write_fifo & ~bus.flush;
  assign w_pop_req  = bus.rd_fifo    & ~bus.flush;
  assign w_push     = w_push_req & ~r_full;
  assign w_pop      = w_pop_req  & ~r_empty;
  assign w_op       = fifo_op_e'({w_push, w_pop});

  always_comb begin
    w_wptr_nxt = r_wptr;
    w_rptr_nxt = r_rptr;
    case (w_op)
      OP_PUSH: w_wptr_nxt = r_wptr + PTR_W'(1);
      OP_POP:  w_rptr_nxt = r_rptr + PTR_W'(1);
      OP_BOTH: begin
        w_wptr_nxt = r_wptr + PTR_W'(1);
        w_rptr_nxt = r_rptr + PTR_W'(1);
      end
      default: ;
    endcase
  end

  // Wrap-bit difference with equal addresses distinguishes full from empty.
  assign w_cnt_nxt   = CNT_W'(w_wptr_nxt - w_rptr_nxt);
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  assign w_full_nxt  = (w_wptr_nxt[ADDR_W-1:0] == w_rptr_nxt[ADDR_W-1:0]) &&
                       (w_wptr_nxt[ADDR_W] != w_rptr_nxt[ADDR_W]);
  assign w_afull_nxt = (w_cnt_nxt >= CNT_W'(AFULL_LVL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_cnt_nxt;
      r_full  <= w_full_nxt;
      r_empty <= w_empty_nxt;
      r_afull <= w_afull_nxt;
      r_ovf   <= r_ovf | (w_push_req & r_full);
      r_udf   <= r_udf | (w_pop_req & r_empty);
    end
  end

  me_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr[ADDR_W-1:0]),
    .i_wdata (bus.data_fifo),
    .i_raddr (r_rptr[ADDR_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

`ifdef ME_FIFO_FWFT_EN
  assign bus.rdata  = w_mem_rdata;
  assign bus.rvalid = ~r_empty;
`else
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  // Head is captured on the popping edge; rdata holds across flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (bus.flush) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_pop;
      if (w_pop) r_rdata <= w_mem_rdata;
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
`endif

  assign bus.wfull        = r_full;
  assign bus.walmost_full = r_afull;
  assign bus.rempty       = r_empty;
  assign bus.count        = r_count;
  assign bus.ovf          = r_ovf;
  assign bus.udf          = r_udf;

endmodule

// File: tb/tb_me_operand_fifo.sv
// Directed self-checking bench for me_operand_fifo (both ME_FIFO_FWFT_EN builds).
module tb_me_operand_fifo;
  import me_operand_fifo_pkg::*;

  localparam int W = M_SIZE;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  me_operand_fifo_if bus ();

  me_operand_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write_fifo = 1'b0;
    bus.rd_fifo    = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    bus.write_fifo = 1'b1;
    bus.data_fifo  = d;
    tick();
    idle();
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.count !== 3'd0 || bus.rempty !== 1'b1 || bus.wfull !== 1'b0 || bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: count=%0d rempty=%b wfull=%b rvalid=%b want 0 1 0 0",
               bus.count, bus.rempty, bus.wfull, bus.rvalid);
    end
    push(W'('h11));
    push(W'('h12));
    push(W'('h13));
    checks++;
    if (bus.count !== 3'd3) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d want 3", bus.count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.rempty !== 1'b1 || bus.wfull !== 1'b0 ||
        bus.walmost_full !== 1'b0 || bus.ovf !== 1'b0 || bus.udf !== 1'b0 || bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count=%0d rempty=%b wfull=%b afull=%b ovf=%b udf=%b rvalid=%b want 0 1 0 0 0 0 0",
               bus.count, bus.rempty, bus.wfull, bus.walmost_full, bus.ovf, bus.udf, bus.rvalid);
    end
`ifndef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'(0)) begin
      errors++;
      $display("FAIL reset_rdata: got %0h want 0", bus.rdata[63:0]);
    end
`endif
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.rempty !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: count=%0d rempty=%b want 0 1", bus.count, bus.rempty);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      push(W'(i));
      checks++;
      if (bus.count !== 3'(i) || bus.walmost_full !== (i >= 3) || bus.wfull !== (i == 4) ||
          bus.rempty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d afull=%b wfull=%b rempty=%b want %0d %b %b 0",
                 i, bus.count, bus.walmost_full, bus.wfull, bus.rempty, i, (i >= 3), (i == 4));
      end
    end
    push(W'('h5));
    checks++;
    if (bus.ovf !== 1'b1 || bus.count !== 3'd4 || bus.wfull !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow: ovf=%b count=%0d wfull=%b want 1 4 1", bus.ovf, bus.count, bus.wfull);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 4; i++) begin
`ifdef ME_FIFO_FWFT_EN
      checks++;
      if (bus.rdata !== W'(i) || bus.rvalid !== 1'b1) begin
        errors++;
        $display("FAIL drain_head_%0d: rdata=%0h rvalid=%b want %0h 1", i, bus.rdata[63:0], bus.rvalid, i);
      end
`endif
      bus.rd_fifo = 1'b1;
      tick();
      idle();
`ifndef ME_FIFO_FWFT_EN
      checks++;
      if (bus.rdata !== W'(i) || bus.rvalid !== 1'b1) begin
        errors++;
        $display("FAIL drain_pop_%0d: rdata=%0h rvalid=%b want %0h 1", i, bus.rdata[63:0], bus.rvalid, i);
      end
      tick();
      checks++;
      if (bus.rvalid !== 1'b0 || bus.rdata !== W'(i)) begin
        errors++;
        $display("FAIL drain_hold_%0d: rvalid=%b rdata=%0h want 0 %0h", i, bus.rvalid, bus.rdata[63:0], i);
      end
`endif
      checks++;
      if (bus.count !== 3'(4 - i)) begin
        errors++;
        $display("FAIL drain_count_%0d: count=%0d want %0d", i, bus.count, 4 - i);
      end
    end
    bus.rd_fifo = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.udf !== 1'b1 || bus.rempty !== 1'b1 || bus.count !== 3'd0 || bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL drain_underflow: udf=%b rempty=%b count=%0d rvalid=%b want 1 1 0 0",
               bus.udf, bus.rempty, bus.count, bus.rvalid);
    end
  endtask

  task automatic test_wrap();
    do_flush();
    push(W'('hA0));
    push(W'('hA1));
    for (int i = 2; i <= 11; i++) begin
`ifdef ME_FIFO_FWFT_EN
      checks++;
      if (bus.rdata !== W'('hA0 + i - 2)) begin
        errors++;
        $display("FAIL wrap_head_%0d: rdata=%0h want %0h", i, bus.rdata[63:0], 'hA0 + i - 2);
      end
`endif
      bus.rd_fifo = 1'b1;
      if (i <= 9) begin
        bus.write_fifo = 1'b1;
        bus.data_fifo  = W'('hA0 + i);
      end
      tick();
      idle();
`ifndef ME_FIFO_FWFT_EN
      checks++;
      if (bus.rdata !== W'('hA0 + i - 2) || bus.rvalid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pop_%0d: rdata=%0h rvalid=%b want %0h 1", i, bus.rdata[63:0], bus.rvalid, 'hA0 + i - 2);
      end
`endif
      checks++;
      if (bus.count !== ((i <= 9) ? 3'd2 : 3'(11 - i))) begin
        errors++;
        $display("FAIL wrap_count_%0d: count=%0d want %0d", i, bus.count, (i <= 9) ? 2 : 11 - i);
      end
    end
    checks++;
    if (bus.ovf !== 1'b0 || bus.udf !== 1'b0 || bus.rempty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_flags: ovf=%b udf=%b rempty=%b want 0 0 1", bus.ovf, bus.udf, bus.rempty);
    end
  endtask

  task automatic test_simultaneous();
    do_flush();
    push(W'('h51));
    push(W'('h52));
    bus.write_fifo = 1'b1;
    bus.data_fifo  = W'('h53);
    bus.rd_fifo    = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.count !== 3'd2 || bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin
      errors++;
      $display("FAIL simul_mid: count=%0d ovf=%b udf=%b want 2 0 0", bus.count, bus.ovf, bus.udf);
    end
`ifndef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'('h51) || bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL simul_mid_data: rdata=%0h rvalid=%b want 51 1", bus.rdata[63:0], bus.rvalid);
    end
`endif
    push(W'('h54));
    push(W'('h55));
    checks++;
    if (bus.count !== 3'd4 || bus.wfull !== 1'b1) begin
      errors++;
      $display("FAIL simul_fill: count=%0d wfull=%b want 4 1", bus.count, bus.wfull);
    end
`ifdef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'('h52)) begin
      errors++;
      $display("FAIL simul_full_head: rdata=%0h want 52", bus.rdata[63:0]);
    end
`endif
    bus.write_fifo = 1'b1;
    bus.data_fifo  = W'('h56);
    bus.rd_fifo    = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.count !== 3'd3 || bus.ovf !== 1'b1 || bus.wfull !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: count=%0d ovf=%b wfull=%b want 3 1 0", bus.count, bus.ovf, bus.wfull);
    end
`ifndef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'('h52)) begin
      errors++;
      $display("FAIL simul_full_data: rdata=%0h want 52", bus.rdata[63:0]);
    end
`endif
    do_flush();
    bus.write_fifo = 1'b1;
    bus.data_fifo  = W'('h57);
    bus.rd_fifo    = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.count !== 3'd1 || bus.udf !== 1'b1 || bus.ovf !== 1'b0 || bus.rempty !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: count=%0d udf=%b ovf=%b rempty=%b want 1 1 0 0",
               bus.count, bus.udf, bus.ovf, bus.rempty);
    end
`ifdef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'('h57) || bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty_head: rdata=%0h rvalid=%b want 57 1", bus.rdata[63:0], bus.rvalid);
    end
`else
    checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== W'('h52)) begin
      errors++;
      $display("FAIL simul_empty_data: rvalid=%b rdata=%0h want 0 52", bus.rvalid, bus.rdata[63:0]);
    end
`endif
  endtask

  task automatic test_flush();
    push(W'('h31));
    push(W'('h32));
    checks++;
    if (bus.count !== 3'd3 || bus.walmost_full !== 1'b1 || bus.udf !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: count=%0d afull=%b udf=%b want 3 1 1", bus.count, bus.walmost_full, bus.udf);
    end
    bus.flush      = 1'b1;
    bus.write_fifo = 1'b1;
    bus.data_fifo  = W'('hFF);
    tick();
    idle();
    checks++;
    if (bus.count !== 3'd0 || bus.rempty !== 1'b1 || bus.walmost_full !== 1'b0 || bus.wfull !== 1'b0 ||
        bus.ovf !== 1'b0 || bus.udf !== 1'b0 || bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: count=%0d rempty=%b afull=%b wfull=%b ovf=%b udf=%b rvalid=%b want 0 1 0 0 0 0 0",
               bus.count, bus.rempty, bus.walmost_full, bus.wfull, bus.ovf, bus.udf, bus.rvalid);
    end
`ifndef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'('h52)) begin
      errors++;
      $display("FAIL flush_rdata_hold: rdata=%0h want 52", bus.rdata[63:0]);
    end
`endif
    push(W'('h44));
`ifdef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'('h44)) begin
      errors++;
      $display("FAIL flush_next_head: rdata=%0h want 44", bus.rdata[63:0]);
    end
`endif
    bus.rd_fifo = 1'b1;
    tick();
    idle();
`ifndef ME_FIFO_FWFT_EN
    checks++;
    if (bus.rdata !== W'('h44) || bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_pop: rdata=%0h rvalid=%b want 44 1", bus.rdata[63:0], bus.rvalid);
    end
`endif
    checks++;
    if (bus.rempty !== 1'b1 || bus.count !== 3'd0 || bus.udf !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: rempty=%b count=%0d udf=%b want 1 0 0", bus.rempty, bus.count, bus.udf);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.data_fifo  = '0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
